// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types: MEM-stage state encoding, widths, EX/MEM and MEM/WB control bundles
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_mem_ctrl_t;

  // Field order of the MEM/WB control word as consumed by the WB stage
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM capture register with load enable and synchronous reset
module ex_mem_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  write_reg,
  input  ex_mem_ctrl_t      ctrl,
  output logic [DATA_W-1:0] alu_result_q,
  output logic [DATA_W-1:0] store_data_q,
  output logic [REG_W-1:0]  write_reg_q,
  output ex_mem_ctrl_t      ctrl_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      write_reg_q  <= '0;
      ctrl_q       <= '0;
    end else if (load) begin
      alu_result_q <= alu_result;
      store_data_q <= store_data;
      write_reg_q  <= write_reg;
      ctrl_q       <= ctrl;
    end
  end

endmodule

// File: rtl/mem_stage_module.sv
// rtl/mem_stage_module.sv - MIPS MEM stage: EX/MEM capture, branch resolve, dmem handshake, MEM/WB register; MEM_ALIGN_CHECK_EN adds misalign_err
module mem_stage_module
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data2_out,
  input  logic [REG_W-1:0]  mux_out,
  input  logic              zero_out,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  output logic              PCSrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              MemtoReg_wb,
  output logic              RegWrite_wb,
  output logic [CNT_W-1:0]  stall_count
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  state_t       state;
  ex_mem_ctrl_t ctrl_in, cap_ctrl;
  mem_wb_ctrl_t wb_ctrl;
  logic [DATA_W-1:0] cap_alu, cap_wdata;
  logic [REG_W-1:0]  cap_reg;
  logic capture, misaligned, go_access;

  assign in_ready  = (state == IDLE);
  assign capture   = in_valid & in_ready;
  assign ctrl_in   = '{mem_to_reg: MemtoReg, reg_write: RegWrite,
                       mem_read: MemRead, mem_write: MemWrite};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (MemRead | MemWrite) && (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign go_access = (MemRead | MemWrite) & ~misaligned;

  ex_mem_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ex_mem_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (capture),
    .alu_result   (alu_result),
    .store_data   (read_data2_out),
    .write_reg    (mux_out),
    .ctrl         (ctrl_in),
    .alu_result_q (cap_alu),
    .store_data_q (cap_wdata),
    .write_reg_q  (cap_reg),
    .ctrl_q       (cap_ctrl)
  );

  // Request lines come straight from the state flop and capture register, so they hold until ack
  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = dmem_req & cap_ctrl.mem_write;
  assign dmem_addr  = cap_alu;
  assign dmem_wdata = cap_wdata;

  assign MemtoReg_wb = wb_ctrl.mem_to_reg;
  assign RegWrite_wb = wb_ctrl.reg_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      PCSrc         <= 1'b0;
      branch_target <= '0;
      wb_valid      <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_write_reg  <= '0;
      wb_ctrl       <= '0;
      stall_count   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err  <= 1'b0;
`endif
    end else begin
      PCSrc    <= 1'b0;
      wb_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      if (state == IDLE) begin
        if (in_valid) begin
          PCSrc         <= Branch & zero_out;
          branch_target <= add_result;
          if (go_access) begin
            state <= ACCESS;
          end else begin
            wb_valid      <= 1'b1;
            wb_read_data  <= '0;
            wb_alu_result <= alu_result;
            wb_write_reg  <= mux_out;
            wb_ctrl       <= '{mem_to_reg: MemtoReg, reg_write: RegWrite & ~misaligned};
`ifdef MEM_ALIGN_CHECK_EN
            misalign_err  <= misaligned;
`endif
          end
        end
      end else begin
        if (stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
        if (dmem_ack) begin
          state         <= IDLE;
          wb_valid      <= 1'b1;
          // A simultaneous read+write is treated as a store
          wb_read_data  <= (cap_ctrl.mem_read & ~cap_ctrl.mem_write) ? dmem_rdata : '0;
          wb_alu_result <= cap_alu;
          wb_write_reg  <= cap_reg;
          wb_ctrl       <= '{mem_to_reg: cap_ctrl.mem_to_reg, reg_write: cap_ctrl.reg_write};
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_module.sv
// tb/tb_mem_stage_module.sv - self-checking bench for mem_stage_module with a transaction-level reference model
module tb_mem_stage_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready;
  logic [31:0] add_result, alu_result, read_data2_out;
  logic [4:0]  mux_out;
  logic zero_out, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic PCSrc, dmem_req, dmem_we, dmem_ack, wb_valid, MemtoReg_wb, RegWrite_wb;
  logic [31:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata, wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;
  logic [15:0] stall_count;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_err;
`endif

  mem_stage_module dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .add_result(add_result), .alu_result(alu_result), .read_data2_out(read_data2_out),
    .mux_out(mux_out), .zero_out(zero_out), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .PCSrc(PCSrc),
    .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg),
    .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb), .stall_count(stall_count)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  typedef struct {
    logic [31:0] add, alu, wd;
    logic [4:0]  mux;
    logic z, m2r, rw, mr, mw, br;
  } txn_t;

  int n_chk = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  // Expected outputs for the cycle following the next rising edge
  logic e_ready = 1'b1, e_req = 1'b0, e_we = 1'b0, e_pcsrc = 1'b0, e_wbv = 1'b0;
  logic e_m2r = 1'b0, e_rw = 1'b0, e_mis = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_target = '0, e_rd = '0, e_alu = '0;
  logic [4:0]  e_reg = '0;
  logic [15:0] e_stall = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("PCSrc", 32'(PCSrc), 32'(e_pcsrc));
      chk("branch_target", branch_target, e_target);
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      chk("wb_read_data", wb_read_data, e_rd);
      chk("wb_alu_result", wb_alu_result, e_alu);
      chk("wb_write_reg", 32'(wb_write_reg), 32'(e_reg));
      chk("MemtoReg_wb", 32'(MemtoReg_wb), 32'(e_m2r));
      chk("RegWrite_wb", 32'(RegWrite_wb), 32'(e_rw));
      chk("stall_count", 32'(stall_count), 32'(e_stall));
`ifdef MEM_ALIGN_CHECK_EN
      chk("misalign_err", 32'(misalign_err), 32'(e_mis));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input txn_t t, input logic v);
    in_valid = v;
    add_result = t.add; alu_result = t.alu; read_data2_out = t.wd; mux_out = t.mux;
    zero_out = t.z; MemtoReg = t.m2r; RegWrite = t.rw;
    MemRead = t.mr; MemWrite = t.mw; Branch = t.br;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    logic [1:0] op;
    t.add = $urandom; t.alu = $urandom; t.wd = $urandom; t.mux = 5'($urandom);
    t.z = 1'($urandom); t.m2r = 1'($urandom); t.rw = 1'($urandom); t.br = 1'($urandom);
    op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    t.mr = op[0]; t.mw = op[1];
    return t;
  endfunction

  task automatic idle();
    drive(rand_txn(), 1'b0);
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    e_pcsrc = 1'b0; e_wbv = 1'b0; e_mis = 1'b0;
    step();
  endtask

  task automatic do_txn(input txn_t t, input int delay, input logic [31:0] rdata);
    logic mem, mis;
    mem = t.mr | t.mw;
`ifdef MEM_ALIGN_CHECK_EN
    mis = mem && (t.alu[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    drive(t, 1'b1);
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    e_pcsrc = t.br & t.z; e_target = t.add; e_mis = mis;
    if (mem && !mis) begin
      e_req = 1'b1; e_ready = 1'b0; e_wbv = 1'b0;
      e_addr = t.alu; e_wdata = t.wd; e_we = t.mw;
    end else begin
      e_wbv = 1'b1; e_rd = '0; e_alu = t.alu; e_reg = t.mux;
      e_m2r = t.m2r; e_rw = t.rw & ~mis;
    end
    step();
    e_pcsrc = 1'b0; e_mis = 1'b0;
    if (mem && !mis) begin
      for (int k = 1; k <= delay; k++) begin
        // in_valid garbage during the access must be ignored
        drive(rand_txn(), 1'($urandom));
        dmem_ack = (k == delay);
        dmem_rdata = (k == delay) ? rdata : $urandom;
        if (e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
        e_wbv = 1'b0;
        if (k == delay) begin
          e_req = 1'b0; e_ready = 1'b1; e_wbv = 1'b1;
          e_rd = (t.mr && !t.mw) ? rdata : 32'h0;
          e_alu = t.alu; e_reg = t.mux; e_m2r = t.m2r; e_rw = t.rw;
        end
        step();
      end
    end
    in_valid = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic reset_expect();
    e_ready = 1'b1; e_req = 1'b0; e_pcsrc = 1'b0; e_wbv = 1'b0; e_mis = 1'b0;
    e_target = '0; e_rd = '0; e_alu = '0; e_reg = '0; e_m2r = 1'b0; e_rw = 1'b0; e_stall = '0;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    t = '{default: 0};
    drive(t, 1'b0);
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;
    idle();

    // R-type
    t = '{default: 0}; t.alu = 32'h22; t.mux = 5'b10000; t.rw = 1'b1;
    do_txn(t, 1, 32'h0);
    chk("lit_rtype_wbv", 32'(wb_valid), 32'h1);
    chk("lit_rtype_alu", wb_alu_result, 32'h22);
    chk("lit_rtype_reg", 32'(wb_write_reg), 32'd16);
    chk("lit_rtype_req", 32'(dmem_req), 32'h0);

    // Load, ack on the third access cycle
    t = '{default: 0}; t.alu = 32'h40; t.mr = 1'b1; t.rw = 1'b1; t.m2r = 1'b1; t.mux = 5'd3;
    do_txn(t, 3, 32'hDEADBEEF);
    chk("lit_load_rdata", wb_read_data, 32'hDEADBEEF);
    chk("lit_load_stall", 32'(stall_count), 32'd3);

    // Store
    t = '{default: 0}; t.alu = 32'h8; t.wd = 32'h2; t.mw = 1'b1;
    do_txn(t, 2, 32'h12345678);
    chk("lit_store_rdata", wb_read_data, 32'h0);
    chk("lit_store_stall", 32'(stall_count), 32'd5);

    // Read and write together: write wins
    t = '{default: 0}; t.alu = 32'hC; t.mr = 1'b1; t.mw = 1'b1;
    do_txn(t, 1, 32'hFFFF0000);
    chk("lit_rw_rdata", wb_read_data, 32'h0);

    // Branch taken, then not taken
    t = '{default: 0}; t.br = 1'b1; t.z = 1'b1; t.add = 32'h100; t.rw = 1'b1;
    do_txn(t, 1, 32'h0);
    chk("lit_br_pcsrc", 32'(PCSrc), 32'h1);
    chk("lit_br_target", branch_target, 32'h100);
    chk("lit_br_rw", 32'(RegWrite_wb), 32'h1);
    idle();
    chk("lit_br_pulse", 32'(PCSrc), 32'h0);
    t.z = 1'b0; t.add = 32'h200;
    do_txn(t, 1, 32'h0);
    chk("lit_nbr_pcsrc", 32'(PCSrc), 32'h0);
    chk("lit_nbr_target", branch_target, 32'h200);

`ifdef MEM_ALIGN_CHECK_EN
    t = '{default: 0}; t.alu = 32'h41; t.mr = 1'b1; t.rw = 1'b1;
    do_txn(t, 1, 32'h0);
    chk("lit_mis_err", 32'(misalign_err), 32'h1);
    chk("lit_mis_req", 32'(dmem_req), 32'h0);
    chk("lit_mis_rw", 32'(RegWrite_wb), 32'h0);
`endif

    // Random traffic, including back-to-back captures
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      do_txn(rand_txn(), int'($urandom_range(1, 4)), $urandom);
    end

    // Reset in the middle of a load, then a late ack
    t = '{default: 0}; t.alu = 32'h80; t.mr = 1'b1; t.rw = 1'b1;
    drive(t, 1'b1); dmem_ack = 1'b0;
    e_pcsrc = 1'b0; e_target = t.add; e_req = 1'b1; e_ready = 1'b0; e_wbv = 1'b0;
    e_addr = t.alu; e_wdata = t.wd; e_we = 1'b0;
    step();
    in_valid = 1'b0;
    if (e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
    step();
    rst = 1'b1;
    reset_expect();
    step();
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_ack = 1'b0;
    chk("lit_rst_req", 32'(dmem_req), 32'h0);
    chk("lit_rst_wbv", 32'(wb_valid), 32'h0);
    chk("lit_rst_stall", 32'(stall_count), 32'h0);
    chk("lit_rst_ready", 32'(in_ready), 32'h1);
    idle();
    idle();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
